// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes and exec-unit state encoding.
// Imported by the ALU control decoder and the execution unit.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_NOP     = 3'b000,
    ALU_AND     = 3'b001,
    ALU_OR      = 3'b010,
    ALU_ADD     = 3'b011,
    ALU_SUB     = 3'b100,
    ALU_MUL     = 3'b101,
    ALU_BEQ_SUB = 3'b110,
    ALU_RSVD    = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } exec_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the ALU execution unit (start/ready/done handshake).
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  import alu_ctrl_pkg::*;

  logic             start_i;
  alu_op_e          ALU_Ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (
    output start_i, ALU_Ctrl_i, src1_i, src2_i,
    input  ready_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, ALU_Ctrl_i, src1_i, src2_i,
    output ready_o, done_o, result_o, zero_o
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// product_o already includes the final step so it can be captured on the done edge.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc, mcand, mplier, addend, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy, last;

  assign addend  = mplier[0] ? mcand : '0;
  assign acc_nxt = acc + addend;
  assign last    = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (load_i) begin
      acc    <= '0;
      mcand  <= mcand_i;
      mplier <= mplier_i;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= last ? '0 : cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

  assign busy_o    = busy;
  assign done_o    = last;
  assign product_o = acc_nxt;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/add/sub/compare, iterative multiply,
// registered result/zero with a one-cycle done pulse per accepted op.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_exec_unit_if.slave bus
);

  exec_state_e      state, state_nxt;
  logic             ready, accept, is_mul, mul_load, mul_busy, mul_done, cmpl;
  logic [WIDTH-1:0] src1, src2, alu_res, product, res_nxt;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, done_q;

  assign src1     = bus.src1_i;
  assign src2     = bus.src2_i;
  assign ready    = (state == ST_IDLE) && !mul_busy;
  assign accept   = bus.start_i && ready;
  assign is_mul   = (bus.ALU_Ctrl_i == ALU_MUL);
  assign mul_load = accept && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (mul_load),
    .mcand_i   (src1),
    .mplier_i  (src2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (product)
  );

  always_comb begin
    alu_res = '0;
    unique case (bus.ALU_Ctrl_i)
      ALU_AND:              alu_res = src1 & src2;
      ALU_OR:               alu_res = src1 | src2;
      ALU_ADD:              alu_res = src1 + src2;
      ALU_SUB, ALU_BEQ_SUB: alu_res = src1 - src2;
      default:              alu_res = '0;
    endcase
  end

  // Compare uses the subtract path; zero on A-B is exactly A==B.
  always_comb begin
    state_nxt = state;
    cmpl      = 1'b0;
    res_nxt   = alu_res;
    unique case (state)
      ST_IDLE: begin
        if (accept && is_mul) state_nxt = ST_MUL;
        cmpl = accept && !is_mul;
      end
      ST_MUL: begin
        res_nxt = product;
        cmpl    = mul_done;
        if (mul_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state  <= state_nxt;
      done_q <= cmpl;
      if (cmpl) begin
        result_q <= res_nxt;
        zero_q   <= (res_nxt == '0);
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;
  import alu_ctrl_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(alu_op_e op, logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      ALU_AND:              return a & b;
      ALU_OR:               return a | b;
      ALU_ADD:              return a + b;
      ALU_SUB, ALU_BEQ_SUB: return a - b;
      ALU_MUL: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
      default:              return '0;
    endcase
  endfunction

  task automatic drive(logic s, alu_op_e op, logic [W-1:0] a, logic [W-1:0] b);
    bus.start_i    = s;
    bus.ALU_Ctrl_i = op;
    bus.src1_i     = a;
    bus.src2_i     = b;
  endtask

  task automatic test_reset();
    int n;
    drive(1'b0, ALU_NOP, '0, '0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done_o); end
    n_checks++; if (bus.result_o !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result_o); end
    n_checks++; if (bus.zero_o !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", bus.zero_o); end
    // Abort a multiply 5 cycles in.
    drive(1'b1, ALU_MUL, 32'd7, 32'd9);
    @(negedge clk);
    drive(1'b0, ALU_NOP, '0, '0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) n++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL rst_abort_done: got %0d pulses want 0", n); end
    n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_abort_ready: got %b want 1", bus.ready_o); end
    n_checks++; if (bus.result_o !== '0) begin n_fail++; $display("FAIL rst_abort_result: got %h want 0", bus.result_o); end
    n_checks++; if (bus.zero_o !== 1'b1) begin n_fail++; $display("FAIL rst_abort_zero: got %b want 1", bus.zero_o); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) n++;
    end
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL rst_abort_late_done: got %0d pulses want 0", n); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 20;
    alu_op_e        ops [N];
    logic [W-1:0]   a [N], b [N];
    ops[0] = ALU_ADD; a[0] = 32'hFFFF_FFFF; b[0] = 32'h1;
    ops[1] = ALU_SUB; a[1] = 32'd5;        b[1] = 32'd7;
    ops[2] = ALU_AND; a[2] = 32'hF0F0_F0F0; b[2] = 32'hFF00_FF00;
    ops[3] = ALU_OR;  a[3] = 32'h1;        b[3] = 32'h2;
    for (int i = 4; i < N; i++) begin
      do ops[i] = alu_op_e'(3'($urandom_range(0, 7))); while (ops[i] == ALU_MUL);
      a[i] = $urandom;
      b[i] = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
    end
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b want 1", i-1, bus.done_o); end
        n_checks++; if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i-1, bus.ready_o); end
        n_checks++; if (bus.result_o !== model(ops[i-1], a[i-1], b[i-1])) begin n_fail++;
          $display("FAIL b2b_result[%0d] op=%s: got %h want %h", i-1, ops[i-1].name(), bus.result_o, model(ops[i-1], a[i-1], b[i-1])); end
        n_checks++; if (bus.zero_o !== (model(ops[i-1], a[i-1], b[i-1]) == 0)) begin n_fail++;
          $display("FAIL b2b_zero[%0d]: got %b want %b", i-1, bus.zero_o, model(ops[i-1], a[i-1], b[i-1]) == 0); end
      end
      if (i < N) drive(1'b1, ops[i], a[i], b[i]);
      else       drive(1'b0, ALU_ADD, 32'h55, 32'h66);
    end
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_done: got %b want 0", bus.done_o); end
    n_checks++; if (bus.result_o !== model(ops[N-1], a[N-1], b[N-1])) begin n_fail++;
      $display("FAIL b2b_hold: got %h want %h", bus.result_o, model(ops[N-1], a[N-1], b[N-1])); end
  endtask

  task automatic mul_once(logic [W-1:0] a, logic [W-1:0] b);
    int cyc, early;
    @(negedge clk);
    drive(1'b1, ALU_MUL, a, b);
    @(negedge clk);
    drive(1'b0, ALU_NOP, '0, '0);
    cyc = 0; early = 0;
    while (bus.ready_o === 1'b0 && cyc < 100) begin
      if (bus.done_o !== 1'b0) early++;
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc != W) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d want %0d", cyc, W); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL mul_early_done: got %0d want 0", early); end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL mul_done: got %b want 1", bus.done_o); end
    n_checks++; if (bus.result_o !== model(ALU_MUL, a, b)) begin n_fail++;
      $display("FAIL mul_result %h*%h: got %h want %h", a, b, bus.result_o, model(ALU_MUL, a, b)); end
    n_checks++; if (bus.zero_o !== (model(ALU_MUL, a, b) == 0)) begin n_fail++;
      $display("FAIL mul_zero: got %b want %b", bus.zero_o, model(ALU_MUL, a, b) == 0); end
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL mul_pulse_width: got %b want 0", bus.done_o); end
  endtask

  task automatic test_mul();
    mul_once(32'h0001_2345, 32'h0000_0100);
    mul_once(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_once(32'h8000_0000, 32'h2);
    mul_once($urandom, 32'h0);
    for (int i = 0; i < 3; i++) mul_once($urandom, $urandom);
  endtask

  task automatic test_mul_stall();
    int cyc, early;
    @(negedge clk);
    drive(1'b1, ALU_MUL, 32'd3, 32'd4);
    @(negedge clk);
    cyc = 0; early = 0;
    while (bus.ready_o === 1'b0 && cyc < 100) begin
      if (bus.done_o !== 1'b0) early++;
      drive(1'b1, alu_op_e'(3'($urandom_range(0, 7))), $urandom, $urandom);
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc != W) begin n_fail++; $display("FAIL stall_cycles: got %0d want %0d", cyc, W); end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL stall_early_done: got %0d want 0", early); end
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b want 1", bus.done_o); end
    n_checks++; if (bus.result_o !== 32'd12) begin n_fail++; $display("FAIL stall_result: got %h want 0000000c", bus.result_o); end
    drive(1'b1, ALU_ADD, 32'd2, 32'd2);
    @(negedge clk);
    drive(1'b0, ALU_NOP, '0, '0);
    n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL done_cycle_accept_done: got %b want 1", bus.done_o); end
    n_checks++; if (bus.result_o !== 32'd4) begin n_fail++; $display("FAIL done_cycle_accept_result: got %h want 00000004", bus.result_o); end
    n_checks++; if (bus.zero_o !== 1'b0) begin n_fail++; $display("FAIL done_cycle_accept_zero: got %b want 0", bus.zero_o); end
    @(negedge clk);
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL no_queued_req: got %b want 0", bus.done_o); end
  endtask

  task automatic test_branch_nop();
    alu_op_e      ops [5] = '{ALU_BEQ_SUB, ALU_BEQ_SUB, ALU_NOP, ALU_RSVD, ALU_BEQ_SUB};
    logic [W-1:0] a [5]   = '{32'd10, 32'd10, 32'hABCD, 32'hABCD, 32'h0};
    logic [W-1:0] b [5]   = '{32'd10, 32'd11, 32'hABCD, 32'hABCD, 32'h0};
    a[4] = $urandom; b[4] = a[4];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, ops[i], a[i], b[i]);
      @(negedge clk);
      drive(1'b0, ALU_NOP, '0, '0);
      n_checks++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL cmp_done[%0d]: got %b want 1", i, bus.done_o); end
      n_checks++; if (bus.result_o !== model(ops[i], a[i], b[i])) begin n_fail++;
        $display("FAIL cmp_result[%0d]: got %h want %h", i, bus.result_o, model(ops[i], a[i], b[i])); end
      n_checks++; if (bus.zero_o !== (model(ops[i], a[i], b[i]) == 0)) begin n_fail++;
        $display("FAIL cmp_zero[%0d]: got %b want %b", i, bus.zero_o, model(ops[i], a[i], b[i]) == 0); end
      @(negedge clk);
      n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL cmp_pulse[%0d]: got %b want 0", i, bus.done_o); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_mul_stall();
    test_branch_nop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Performs the operation on two operands.
- Logic ops, add, sub and branch-compare complete in one cycle; multiply is an iterative shift-add taking WIDTH cycles.
- Uses a start/ready/done handshake so the datapath stalls for the duration of a multiply.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset, synchronous to clk_i and active-high.
- start_i  input  1  request to execute; accepted only when ready_o=1.
- ALU_Ctrl_i  input  3  operation code, sampled at accept.
- src1_i  input  WIDTH  operand A, sampled at accept.
- src2_i  input  WIDTH  operand B, sampled at accept.
- ready_o  output  1  unit can accept a request this cycle.
- done_o  output  1  one-cycle pulse: result_o/zero_o are valid and newly updated.
- result_o  output  WIDTH  registered result; holds its value until the next completion.
- zero_o  output  1  registered; 1 iff the result written at the same completion equals 0.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, ready_o=1, done_o=0, result_o=0, zero_o=1, iteration counter=0.
  - Reset has priority over everything; it aborts an in-flight multiply with no done_o.
- Accept: start_i=1 and ready_o=1 at a rising edge (cycle A). All inputs are latched; later input changes have no effect.
- Op codes:
  - 000 nop: result 0.
  - 001 and: A&B.
  - 010 or: A|B.
  - 011 add: A+B.
  - 100 sub: A-B.
  - 101 mul: low WIDTH bits of A*B.
  - 110 branch compare: A-B, with zero_o set iff A==B.
  - 111 reserved: treated as nop.
- Arithmetic: add, sub and mul wrap modulo 2^WIDTH; there is no overflow or carry output. Operands are unsigned; the low WIDTH product bits are sign-agnostic.
- Single-cycle ops (every code except 101):
  - result_o, zero_o and done_o=1 appear in cycle A+1.
  - State stays IDLE and ready_o stays 1, giving back-to-back throughput of 1 op per cycle.
- Multiply, state machine IDLE -> MUL -> IDLE:
  - At accept: acc=0, mcand=A, mplier=B, cnt=0, state=MUL, ready_o=0 from cycle A+1.
  - Each MUL edge: if mplier[0], acc+=mcand (WIDTH bits, wrapping); then mcand<<=1, mplier>>=1, cnt++.
  - On the edge where cnt==WIDTH-1: result_o=final acc, zero_o updated, done_o=1, state=IDLE, ready_o=1.
  - done_o and ready_o are therefore high in cycle A+WIDTH+1.
  - There is no early termination; latency is fixed regardless of operand values.
- done_o is high for exactly one cycle per accepted op. It is low in every cycle with no completion, including every MUL cycle before the last.
- start_i while ready_o=0 is ignored and not queued; the requester must hold or re-assert it.
- A new request is accepted in the same cycle done_o is high (ready_o=1). Its completion follows normally: done_o high again the next cycle for single-cycle ops.
- result_o and zero_o change only at completions or reset.

Decomposition:
- Shared package alu_ctrl_pkg holds the 3-bit op-code constants (NOP, AND, OR, ADD, SUB, MUL, BEQ_SUB, RSVD) and the state enum. The ALU control decoder and this unit both import it; no literal codes appear in either block.
- One sub-module, alu_mul_iter:
  - Contains the shift-add datapath and counter.
  - Interface: load, operands, busy, done, product.
- alu_exec_unit contains the op mux, the result/zero registers and the handshake.

Test Plan (WIDTH=32):
- Reset then idle -> ready_o=1, done_o=0, result_o=0, zero_o=1. Hold rst_i for 3 cycles mid-multiply (A=7, B=9, 5 cycles in) -> no done_o; ready_o=1 and result_o=0 on the cycle after release.
- Back-to-back over 4 consecutive cycles: add 0xFFFFFFFF+1; sub 5-7; and 0xF0F0F0F0&0xFF00FF00; or 0x1&0x2 -> done_o high 4 consecutive cycles. Results, in order:
  - 0x00000000 with zero_o=1
  - 0xFFFFFFFE with zero_o=0
  - 0xF000F000
  - 0x00000003
- mul 0x00012345*0x00000100 -> ready_o low for exactly 32 cycles; done_o single pulse in cycle A+33; result 0x01234500. Then mul 0xFFFFFFFF*0xFFFFFFFF -> result 0x00000001.
- start_i held high with changing operands during a multiply (A=3, B=4) -> extra requests ignored; result 12. A request presented in the done cycle (add 2+2) is accepted and gives result 4 one cycle later.
- Branch compare 10 vs 10 -> zero_o=1, result 0. Compare 10 vs 11 -> zero_o=0, result 0xFFFFFFFF. Codes 000 and 111 with A=B=0xABCD -> result 0, zero_o=1, single-cycle done.
